// File: rtl/mult_sequencer_if.sv
// EX-side request/response bundle for the multi-cycle multiply sequencer.
interface mult_sequencer_if #(
  parameter int WIDTH = 16
);
  logic [5:0]       alu_control;
  logic             op_valid;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;

  modport master (
    output alu_control, op_valid, src_a, src_b, flush,
    input  stall, busy, done, result_hi, result_lo
  );

  modport slave (
    input  alu_control, op_valid, src_a, src_b, flush,
    output stall, busy, done, result_hi, result_lo
  );
endinterface

// File: rtl/mult_sequencer.sv
// Radix-2 shift-add unsigned multiplier sequenced beside the EX-stage ALU.
// Latency: issue at T -> done pulse at T+WIDTH+1; HI/LO registered on DONE entry.
// Backpressure: stall held T..T+WIDTH so EX holds the MULT; flush aborts a run.
module mult_sequencer #(
  parameter int         WIDTH     = 16,
  parameter int         CTR_W     = 5,
  parameter logic [5:0] MULT_CODE = 6'b010110
) (
  input  logic           clk,
  input  logic           reset,
  mult_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CTR_W-1:0] LAST = CTR_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CTR_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               issue;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   wide;
  logic [2*WIDTH-1:0] step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    issue = bus.op_valid && (bus.alu_control == MULT_CODE) && !bus.flush;

    // Carry out of the upper-half add is shifted back in as the new MSB.
    sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    wide = {sum, acc_q[WIDTH-1:0]};
    step = wide[2*WIDTH:1];

    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      IDLE: begin
        if (issue) begin
          mcand_d = bus.src_a;
          acc_d   = {{WIDTH{1'b0}}, bus.src_b};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = DONE;
            hi_d    = step[2*WIDTH-1:WIDTH];
            lo_d    = step[WIDTH-1:0];
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.stall     = (state_q == RUN) || ((state_q == IDLE) && issue);
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.result_hi = hi_q;
  assign bus.result_lo = lo_q;

endmodule
